serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle A − B − Bin engine.
- Complements the combinational ripple adders. Trades latency (one bit per clock) for a single full-subtractor cell.
- Sits beside the adder blocks in the ALU datapath. Host uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only when ready (IDLE or DONE).
- A  input  WIDTH  minuend; captured on accepted start.
- B  input  WIDTH  subtrahend; captured on accepted start.
- Bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result registers update.
- D  output  WIDTH  difference.
- Bout  output  1  final borrow-out; 1 when unsigned A < B + Bin.
- V  output  1  signed overflow.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: rst_n sampled low at a clk rising edge resets the block.
- Reset values:
  - state=IDLE.
  - busy=0, done=0, D=0, Bout=0, V=0.
  - Internal shift registers, borrow flop and bit counter = 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Capture A, B into shift registers; borrow flop <= Bin; count <= 0.
  - Next state RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - Process LSB-first: a = A_sh[0], b = B_sh[0], c = borrow.
  - diff = a^b^c.
  - borrow_next = (~a & b) | (~a & c) | (b & c).
  - Shift diff into the result shift register from the MSB side; shift A_sh and B_sh right.
  - count increments.
  - When count = WIDTH−1: load D, Bout (= borrow_next) and V, then go to DONE.
- V = (A[WIDTH−1] ^ B[WIDTH−1]) & (A[WIDTH−1] ^ D[WIDTH−1]), using the captured operands.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 here is accepted exactly as in IDLE (next state RUN).
  - Otherwise return to IDLE.
- Latency: start accepted at edge k → done high during the cycle following edge k+WIDTH. For WIDTH=8, done is high 8 cycles after acceptance. Back-to-back throughput is WIDTH+1 cycles per operation.
- busy=1 only in RUN. start while busy is ignored, with no side effects.
- D, Bout and V change only on entry to DONE. They hold their values through IDLE and the next RUN until the next completion.
- Inputs A, B and Bin may change freely after acceptance; they do not affect the operation in flight.
- Reset mid-RUN: the operation is aborted and all outputs return to their reset values on that edge. No done pulse is produced.
- Reset asserted together with start: reset wins.
- Counter width: $clog2(WIDTH). There is no wrap, because the terminal compare occurs at WIDTH−1.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_ZERO_FLAG_EN.
- Defined:
  - Adds output port Z (1 bit). Z is 1 when the completed D == 0.
  - Z updates together with D on entry to DONE.
  - Reset value 0.
  - Cleared by mid-operation reset like the other outputs.
- Undefined:
  - Port Z is absent.
  - No zero-detect logic is built.
  - All other behaviour is identical.

Decomposition:
- Shared package (alu_pkg) holds:
  - the sub_state_t enum {IDLE, RUN, DONE};
  - the default width constant ALU_WIDTH = 8.
- Natural sub-module: one_bit_subtractor (Dout, Bout from A, B, Bin). It is the combinational full-subtractor cell, instantiated once and fed by the shift-register LSBs and the borrow flop.
- The FSM, counter and shift registers stay in serial_subtractor.

Test Plan:
- A=8'h35, B=8'h12, Bin=0, start pulse → busy high for 8 cycles, then done pulse; D=8'h23, Bout=0, V=0.
- A=8'h00, B=8'h01, Bin=0 → D=8'hFF, Bout=1, V=0.
- A=8'h80, B=8'h01, Bin=0 → D=8'h7F, Bout=0, V=1. Also A=8'h7F, B=8'hFF → D=8'h80, Bout=1, V=1.
- A=8'h10, B=8'h0F, Bin=1 → D=8'h00, Bout=0. Z=1 when SERIAL_SUBTRACTOR_ZERO_FLAG_EN is defined; port absent otherwise.
- Start A=8'h35, B=8'h12; at cycle 3 pulse start with A=8'hFF, B=8'h00 → ignored; result still 8'h23. Then issue start during the done cycle with A=8'h05, B=8'h03 → accepted; D=8'h02 after a further 8 cycles.
- Start an operation; drive rst_n=0 at cycle 4 of RUN → next edge busy=0, D=0, Bout=0, V=0, no done. A fresh start afterwards completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: the serial subtractor state type and the
// default operand width used by the bit-serial engines.
package alu_pkg;

  // Serial subtractor control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Default operand/result width for the ALU datapath blocks.
  localparam int ALU_WIDTH = 8;

  // Counter width for a bit-serial engine of the given width; never below
  // one bit so the counter stays a legal vector at the smallest width.
  function automatic int serial_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_one_bit.sv
// Combinational full-subtractor cell: Dout = A - B - Bin (one bit),
// Bout is the borrow propagated to the next more significant bit.
module one_bit_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Dout,
  output logic Bout
);

  // Difference bit and borrow-out of a single bit position.
  always_comb begin
    Dout = A ^ B ^ Bin;
    Bout = (~A & B) | (~A & Bin) | (B & Bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin engine with a start/busy/done handshake.
// One difference bit is produced per clock, LSB first, through a single
// full-subtractor cell. Result registers (D, Bout, V) update only when an
// operation completes and hold until the next completion.
//
// Optional build macro: SERIAL_SUBTRACTOR_ZERO_FLAG_EN adds output Z, set
// when the completed difference is zero.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; result registers hold the last result
// RUN   | one bit per cycle through the subtractor cell, LSB first
// DONE  | result registers just loaded; done pulses, start accepted
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
  ,
  output logic             Z
`endif
);

  localparam int CW = serial_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sub_state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_nxt;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;
  logic             cell_d;
  logic             cell_b;
  logic             accept;
  logic             last;

  // Single subtractor cell fed by the operand LSBs and the running borrow.
  one_bit_subtractor u_cell (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Bin  (borrow),
    .Dout (cell_d),
    .Bout (cell_b)
  );

  // Result as it will look once this cycle's difference bit enters from the MSB side.
  assign r_nxt = {cell_d, r_sh[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake outputs; start is only honoured when ready.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, serial shifting and bit counter. The counter stops at
  // its terminal value rather than wrapping, since completion is decoded there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else if (accept) begin
      a_sh   <= A;
      b_sh   <= B;
      r_sh   <= '0;
      borrow <= Bin;
      cnt    <= '0;
      a_msb  <= A[WIDTH-1];
      b_msb  <= B[WIDTH-1];
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      r_sh   <= r_nxt;
      borrow <= cell_b;
      if (!last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Result registers load only on the final RUN cycle (entry to DONE).
  // Overflow uses the operand sign bits captured at acceptance, since the
  // live inputs may already carry the next operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      D    <= '0;
      Bout <= 1'b0;
      V    <= 1'b0;
    end else if (last) begin
      D    <= r_nxt;
      Bout <= cell_b;
      V    <= (a_msb ^ b_msb) & (a_msb ^ cell_d);
    end
  end

`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
  // Zero flag tracks the completed difference and updates with D.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Z <= 1'b0;
    end else if (last) begin
      Z <= (r_nxt == '0);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vector table,
// hand-written handshake/reset sequences, and randomized operations checked
// against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bout;
  logic         V;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
  logic         Z;
`endif

  int n_total = 0;
  int n_pass  = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .V     (V)
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    ,
    .Z     (Z)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bout;
    logic         v;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output logic [W-1:0] d, output logic bout, output logic v);
    int ua, ub, full, sa, sb, sr;
    ua   = int'(a);
    ub   = int'(b);
    full = ua - ub - int'(bin);
    d    = full[W-1:0];
    bout = (full < 0);
    sa   = (ua >= 128) ? ua - 256 : ua;
    sb   = (ub >= 128) ? ub - 256 : ub;
    sr   = sa - sb - int'(bin);
    v    = (sr < -128) || (sr > 127);
  endtask

  // Called at posedge+1: present a start for one cycle.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts cycles from acceptance until done, bounded.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      n_total++;
      $display("FAIL timeout: done not seen within %0d cycles", cyc);
    end
  endtask

  task automatic run_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic bin);
    logic [W-1:0] ed;
    logic eb, ev;
    int cyc, bc;
    ref_sub(a, b, bin, ed, eb, ev);
    start_op(a, b, bin);
    A = ~a; B = ~b; Bin = ~bin;
    wait_done(cyc, bc);
    check({tag, " latency"}, cyc, W);
    check({tag, " busy_cycles"}, bc, W);
    check({tag, " D"}, int'(D), int'(ed));
    check({tag, " Bout"}, int'(Bout), int'(eb));
    check({tag, " V"}, int'(V), int'(ev));
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    check({tag, " Z"}, int'(Z), int'(ed == '0));
`endif
  endtask

  initial begin
    int cyc, bc, seen;
    logic [W-1:0] ra, rb;
    logic rbin;

    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[4] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset D", int'(D), 0);
    check("reset Bout", int'(Bout), 0);
    check("reset V", int'(V), 0);
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    check("reset Z", int'(Z), 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
      A = 8'hA5; B = 8'h5A; Bin = 1'b1;
      wait_done(cyc, bc);
      check($sformatf("vec%0d latency", i), cyc, W);
      check($sformatf("vec%0d busy_cycles", i), bc, W);
      check($sformatf("vec%0d D", i), int'(D), int'(vecs[i].d));
      check($sformatf("vec%0d Bout", i), int'(Bout), int'(vecs[i].bout));
      check($sformatf("vec%0d V", i), int'(V), int'(vecs[i].v));
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
      check($sformatf("vec%0d Z", i), int'(Z), int'(vecs[i].d == '0));
`endif
      @(posedge clk); #1;
      check($sformatf("vec%0d done_pulse_len", i), int'(done), 0);
      check($sformatf("vec%0d D_hold", i), int'(D), int'(vecs[i].d));
    end

    // Start while busy is ignored; start during DONE is accepted.
    start_op(8'h35, 8'h12, 1'b0);
    @(posedge clk); #1;
    start_op(8'hFF, 8'h00, 1'b0);
    wait_done(cyc, bc);
    check("busy_start latency", cyc, W - 2);
    check("busy_start D", int'(D), 8'h23);
    start_op(8'h05, 8'h03, 1'b0);
    wait_done(cyc, bc);
    check("b2b latency", cyc, W);
    check("b2b D", int'(D), 8'h02);
    check("b2b Bout", int'(Bout), 0);

    // Reset in the middle of RUN aborts the operation.
    start_op(8'hAA, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst busy", int'(busy), 0);
    check("midrst done", int'(done), 0);
    check("midrst D", int'(D), 0);
    check("midrst Bout", int'(Bout), 0);
    check("midrst V", int'(V), 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("midrst no_done", seen, 0);
    run_and_check("after_rst", 8'h80, 8'h7F, 1'b1);

    // Reset together with start: reset wins.
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b1; A = 8'h12; B = 8'h34;
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    check("rst_vs_start busy", int'(busy), 0);
    check("rst_vs_start D", int'(D), 0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      if (i % 10 == 0) rb = ra;
      run_and_check($sformatf("rnd%0d", i), ra, rb, rbin);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
